// File: rtl/arm_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
package arm_pkg;

  localparam int unsigned REG_BITS = 4;

  // fwd_sel encoding: 0 selects the register file, k selects entry k-1.
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic                wb_en;
    logic                mem_read;
    logic [REG_BITS-1:0] dest;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// Per-source priority search over the scoreboard: youngest matching writer
// decides between a forwarding select and a stall.
module fwd_match
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic [REG_BITS-1:0]   src,
  input  logic                  used,
  input  sb_entry_t [DEPTH-1:0] entries,
  output logic                  stall,
  output logic [SEL_W-1:0]      sel
);

  logic found;

  always_comb begin
    stall = 1'b0;
    sel   = SEL_W'(FWD_RF);
    found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && used && entries[i].valid && entries[i].wb_en &&
          (entries[i].dest == src)) begin
        found = 1'b1;
        // Load data is not available yet in entries younger than LOAD_LAT.
        if (!FWD_EN || (entries[i].mem_read && (i < LOAD_LAT))) begin
          stall = 1'b1;
        end else begin
          sel = SEL_W'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit: tracks in-flight writes in a shift-register
// scoreboard, resolves both ID sources, and counts hazard stall cycles.
module hazard_scoreboard
  import arm_pkg::*;
#(
  parameter int unsigned REG_BITS = arm_pkg::REG_BITS,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] src1,
  input  logic [REG_BITS-1:0] src2,
  input  logic                src1_used,
  input  logic                two_src,
  input  logic                issue_wb_en,
  input  logic                issue_mem_read,
  input  logic [REG_BITS-1:0] issue_dest,
  input  logic                flush,
  input  logic                mem_ready,
  output logic                hazard,
  output logic                freeze,
  output logic [SEL_W-1:0]    fwd_sel1,
  output logic [SEL_W-1:0]    fwd_sel2,
  output logic [CNT_W-1:0]    stall_count
);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  logic             stall1, stall2;
  logic [SEL_W-1:0] sel1, sel2;

  fwd_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .FWD_EN   (FWD_EN),
    .SEL_W    (SEL_W)
  ) u_fwd_src1 (
    .src     (src1),
    .used    (src1_used),
    .entries (sb_q),
    .stall   (stall1),
    .sel     (sel1)
  );

  fwd_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .FWD_EN   (FWD_EN),
    .SEL_W    (SEL_W)
  ) u_fwd_src2 (
    .src     (src2),
    .used    (two_src),
    .entries (sb_q),
    .stall   (stall2),
    .sel     (sel2)
  );

  // A stalled instruction reads nothing, so its selects are parked on the RF.
  assign hazard      = stall1 | stall2;
  assign fwd_sel1    = hazard ? SEL_W'(FWD_RF) : sel1;
  assign fwd_sel2    = hazard ? SEL_W'(FWD_RF) : sel2;
  assign freeze      = ~mem_ready;
  assign stall_count = stall_count_q;

  // Shift on ready cycles; entry 0 takes the issuing instruction or a bubble.
  always_comb begin
    sb_d          = sb_q;
    stall_count_d = stall_count_q;
    if (mem_ready) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sb_d[i] = sb_q[i-1];
      end
      if (hazard || flush) begin
        sb_d[0] = SB_BUBBLE;
      end else begin
        sb_d[0].valid    = 1'b1;
        sb_d[0].wb_en    = issue_wb_en;
        sb_d[0].mem_read = issue_mem_read;
        sb_d[0].dest     = issue_dest;
      end
      if (hazard && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      sb_q          <= sb_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (forwarding, stall-only,
// 2-bit counter) share one stimulus stream and are checked against a model.
module tb_hazard_scoreboard;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] src1, src2, issue_dest;
  logic       src1_used, two_src, issue_wb_en, issue_mem_read, flush, mem_ready;

  logic        hz  [NI];
  logic        frz [NI];
  logic [1:0]  s1  [NI];
  logic [1:0]  s2  [NI];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  hazard_scoreboard u_dut_fwd (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_used(src1_used),
    .two_src(two_src), .issue_wb_en(issue_wb_en), .issue_mem_read(issue_mem_read),
    .issue_dest(issue_dest), .flush(flush), .mem_ready(mem_ready),
    .hazard(hz[0]), .freeze(frz[0]), .fwd_sel1(s1[0]), .fwd_sel2(s2[0]),
    .stall_count(cnt0)
  );

  hazard_scoreboard #(.FWD_EN(1'b0)) u_dut_stall (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_used(src1_used),
    .two_src(two_src), .issue_wb_en(issue_wb_en), .issue_mem_read(issue_mem_read),
    .issue_dest(issue_dest), .flush(flush), .mem_ready(mem_ready),
    .hazard(hz[1]), .freeze(frz[1]), .fwd_sel1(s1[1]), .fwd_sel2(s2[1]),
    .stall_count(cnt1)
  );

  hazard_scoreboard #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_used(src1_used),
    .two_src(two_src), .issue_wb_en(issue_wb_en), .issue_mem_read(issue_mem_read),
    .issue_dest(issue_dest), .flush(flush), .mem_ready(mem_ready),
    .hazard(hz[2]), .freeze(frz[2]), .fwd_sel1(s1[2]), .fwd_sel2(s2[2]),
    .stall_count(cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a log of everything that entered the pipe, indexed by shift count.
  typedef struct packed {
    bit       v;
    bit       wb;
    bit       ld;
    bit [3:0] d;
  } ins_t;

  ins_t lg    [NI][256];
  int   adv   [NI];
  int   cnt_m [NI];
  bit   fe    [NI] = '{1'b1, 1'b0, 1'b1};
  int   cap   [NI] = '{65535, 65535, 3};
  bit   exp_hz [NI];
  int   exp_s1 [NI];
  int   exp_s2 [NI];

  function automatic logic [15:0] act_cnt(int k);
    if (k == 0) return cnt0;
    if (k == 1) return cnt1;
    return 16'(cnt2);
  endfunction

  function automatic void find(int k, logic used, logic [3:0] s, output bit st, output int sel);
    ins_t e;
    int   t;
    st  = 1'b0;
    sel = 0;
    if (used !== 1'b1) return;
    for (int a = 0; a < 3; a++) begin
      t = adv[k] - 1 - a;
      if (t < 0) return;
      e = lg[k][t % 256];
      if (e.v && e.wb && (e.d == s)) begin
        if (!fe[k] || (e.ld && a < 1)) st = 1'b1;
        else sel = a + 1;
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    bit st1, st2;
    int sl1, sl2;
    for (int k = 0; k < NI; k++) begin
      find(k, src1_used, src1, st1, sl1);
      find(k, two_src, src2, st2, sl2);
      exp_hz[k] = st1 | st2;
      exp_s1[k] = exp_hz[k] ? 0 : sl1;
      exp_s2[k] = exp_hz[k] ? 0 : sl2;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      adv[k]   = 0;
      cnt_m[k] = 0;
    end
  endfunction

  task automatic tick();
    ins_t e;
    model_eval();
    for (int k = 0; k < NI; k++) begin
      if (mem_ready) begin
        e = (exp_hz[k] || flush) ? ins_t'(0) : {1'b1, issue_wb_en, issue_mem_read, issue_dest};
        lg[k][adv[k] % 256] = e;
        adv[k]++;
        if (exp_hz[k] && cnt_m[k] < cap[k]) cnt_m[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit u1, logic [3:0] a, bit u2, logic [3:0] b,
                        bit wb, bit ld, logic [3:0] d, bit fl, bit mr);
    src1_used = u1; src1 = a; two_src = u2; src2 = b;
    issue_wb_en = wb; issue_mem_read = ld; issue_dest = d;
    flush = fl; mem_ready = mr;
  endtask

  task automatic drain();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    for (int k = 0; k < NI; k++) begin
      n_cmp++; if (frz[k] !== 1'b1) begin n_bad++; $display("FAIL reset_freeze[%0d] got=%b want=1", k, frz[k]); end
      n_cmp++; if (hz[k] !== 1'b0) begin n_bad++; $display("FAIL reset_hazard[%0d] got=%b want=0", k, hz[k]); end
      n_cmp++; if (s1[k] !== 2'd0 || s2[k] !== 2'd0) begin n_bad++; $display("FAIL reset_sel[%0d] got=%0d/%0d want=0/0", k, s1[k], s2[k]); end
      n_cmp++; if (act_cnt(k) !== 16'd0) begin n_bad++; $display("FAIL reset_count[%0d] got=%0d want=0", k, act_cnt(k)); end
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (frz[0] !== 1'b0) begin n_bad++; $display("FAIL reset_freeze_ready got=%b want=0", frz[0]); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu_fwd();
    int want [4] = '{1, 2, 3, 0};
    drain();
    set_in(0, 0, 0, 0, 1, 0, 4'd3, 0, 1);
    tick();
    set_in(1, 4'd3, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (s1[0] !== 2'(want[c]) || hz[0] !== 1'b0) begin n_bad++; $display("FAIL alu_fwd c%0d got sel1=%0d hz=%b want sel1=%0d hz=0", c, s1[0], hz[0], want[c]); end
      tick();
    end
  endtask

  task automatic test_stall_only();
    bit want [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    drain();
    set_in(0, 0, 0, 0, 1, 0, 4'd3, 0, 1);
    tick();
    set_in(1, 4'd3, 0, 0, 1, 0, 4'd8, 0, 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (hz[1] !== want[c] || s1[1] !== 2'd0) begin n_bad++; $display("FAIL stall_only c%0d got hz=%b sel1=%0d want hz=%b sel1=0", c, hz[1], s1[1], want[c]); end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [15:0] c0;
    drain();
    set_in(0, 0, 0, 0, 1, 1, 4'd4, 0, 1);
    tick();
    set_in(0, 0, 1, 4'd4, 1, 0, 4'd6, 0, 1);
    c0 = cnt0;
    #1;
    n_cmp++; if (hz[0] !== 1'b1 || s2[0] !== 2'd0) begin n_bad++; $display("FAIL load_use_stall got hz=%b sel2=%0d want hz=1 sel2=0", hz[0], s2[0]); end
    tick();
    set_in(1, 4'd6, 1, 4'd4, 1, 0, 4'd6, 0, 1);
    #1;
    n_cmp++; if (hz[0] !== 1'b0 || s2[0] !== 2'd2) begin n_bad++; $display("FAIL load_use_fwd got hz=%b sel2=%0d want hz=0 sel2=2", hz[0], s2[0]); end
    n_cmp++; if (s1[0] !== 2'd0) begin n_bad++; $display("FAIL load_use_bubble got sel1=%0d want 0", s1[0]); end
    n_cmp++; if (cnt0 !== c0 + 16'd1) begin n_bad++; $display("FAIL load_use_count got=%0d want=%0d", cnt0, c0 + 16'd1); end
    tick();
  endtask

  task automatic test_youngest_flush();
    drain();
    set_in(0, 0, 0, 0, 1, 0, 4'd2, 0, 1);
    tick();
    tick();
    set_in(1, 4'd2, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_cmp++; if (s1[0] !== 2'd1) begin n_bad++; $display("FAIL youngest got sel1=%0d want 1", s1[0]); end
    set_in(0, 0, 0, 0, 1, 0, 4'd7, 1, 1);
    tick();
    set_in(1, 4'd7, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_cmp++; if (s1[0] !== 2'd0 || hz[0] !== 1'b0) begin n_bad++; $display("FAIL flush_bubble got sel1=%0d hz=%b want 0/0", s1[0], hz[0]); end
    tick();
  endtask

  task automatic test_freeze();
    logic [15:0] c0;
    drain();
    set_in(0, 0, 0, 0, 1, 0, 4'd12, 0, 1);
    tick();
    set_in(1, 4'd12, 0, 0, 1, 0, 4'd11, 1, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (s1[0] !== 2'd1 || frz[0] !== 1'b1) begin n_bad++; $display("FAIL freeze_hold c%0d got sel1=%0d frz=%b want 1/1", c, s1[0], frz[0]); end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    set_in(1, 4'd12, 1, 4'd11, 0, 0, 0, 0, 1);
    #1;
    n_cmp++; if (s1[0] !== 2'd2 || s2[0] !== 2'd0) begin n_bad++; $display("FAIL freeze_flush got sel1=%0d sel2=%0d want 2/0", s1[0], s2[0]); end
    drain();
    set_in(0, 0, 0, 0, 1, 1, 4'd9, 0, 1);
    tick();
    set_in(1, 4'd9, 0, 0, 1, 0, 4'd10, 1, 0);
    c0 = cnt0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (hz[0] !== 1'b1 || cnt0 !== c0) begin n_bad++; $display("FAIL freeze_count c%0d got hz=%b cnt=%0d want 1/%0d", c, hz[0], cnt0, c0); end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    set_in(1, 4'd9, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_cmp++; if (cnt0 !== c0 + 16'd1 || s1[0] !== 2'd2) begin n_bad++; $display("FAIL freeze_release got cnt=%0d sel1=%0d want %0d/2", cnt0, s1[0], c0 + 16'd1); end
  endtask

  task automatic test_saturation();
    logic [15:0] c0;
    drain();
    c0 = cnt0;
    for (int r = 0; r < 5; r++) begin
      set_in(0, 0, 0, 0, 1, 1, 4'd13, 0, 1);
      tick();
      set_in(1, 4'd13, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    #1;
    n_cmp++; if (cnt0 !== c0 + 16'd5) begin n_bad++; $display("FAIL sat_wide got=%0d want=%0d", cnt0, c0 + 16'd5); end
    n_cmp++; if (cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_narrow got=%0d want=3", cnt2); end
  endtask

  task automatic test_random();
    logic [3:0] pool [4] = '{4'd0, 4'd1, 4'd2, 4'd15};
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
             1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
             pool[$urandom_range(0, 3)], 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) != 0));
      #1;
      model_eval();
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (hz[k] !== exp_hz[k] || s1[k] !== 2'(exp_s1[k]) || s2[k] !== 2'(exp_s2[k]) ||
            frz[k] !== ~mem_ready || act_cnt(k) !== 16'(cnt_m[k])) begin
          n_bad++;
          $display("FAIL random c%0d dut%0d got hz=%b s1=%0d s2=%0d frz=%b cnt=%0d want hz=%b s1=%0d s2=%0d frz=%b cnt=%0d",
                   c, k, hz[k], s1[k], s2[k], frz[k], act_cnt(k),
                   exp_hz[k], exp_s1[k], exp_s2[k], ~mem_ready, cnt_m[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drain();
    set_in(0, 0, 0, 0, 1, 0, 4'd5, 0, 1);
    repeat (3) tick();
    set_in(1, 4'd5, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_cmp++; if (s1[0] !== 2'd1 || hz[1] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre got sel1=%0d hz1=%b want 1/1", s1[0], hz[1]); end
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (hz[k] !== 1'b0 || s1[k] !== 2'd0 || act_cnt(k) !== 16'd0) begin
        n_bad++;
        $display("FAIL rst_mid dut%0d got hz=%b sel1=%0d cnt=%0d want 0/0/0", k, hz[k], s1[k], act_cnt(k));
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_stall_only();
    test_load_use();
    test_youngest_flush();
    test_freeze();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
